// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: synchronises the pins to clk, deserialises MOSI and serialises the reply byte on MISO.
// Optional per-frame byte counter and frame_end pulse when SPI_SLAVE_FRAME_COUNT_EN is defined.
module spi_byte_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       ss,
    input  logic [7:0] send_data,
    output logic       send_ready,
    output logic [7:0] recv_data,
    output logic       recv_ready
`ifdef SPI_SLAVE_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_bytes,
    output logic       frame_end
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;
    localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_meta, mosi_meta, ss_meta;
    logic sclk_s, mosi_s, ss_s;
    logic sclk_d, ss_d;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [2:0] flush_cnt;
    logic armed;
    logic frame_start;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [6:0] tx_shift;
    logic       byte_done;
    logic       seen_rise;

    assign sclk_s = sclk_meta[SYNC_STAGES-1];
    assign mosi_s = mosi_meta[SYNC_STAGES-1];
    assign ss_s   = ss_meta[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta <= '0;
            mosi_meta <= '0;
            ss_meta   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            sclk_meta <= {sclk_meta[SYNC_STAGES-2:0], sclk};
            mosi_meta <= {mosi_meta[SYNC_STAGES-2:0], mosi};
            ss_meta   <= {ss_meta[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            ss_rise   <= ss_s & ~ss_d;
            ss_fall   <= ~ss_s & ss_d;
        end
    end

    // The synchroniser resets to ss=1, so a pin already low at reset release looks like a fall.
    // Frames are only accepted once the flushed chain has shown ss genuinely high.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_CYCLES)
                flush_cnt <= flush_cnt + 3'd1;
            else if (ss_s && ss_d)
                armed <= 1'b1;
        end
    end

    assign frame_start = (state == IDLE) && ss_fall && armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            miso       <= 1'b0;
            send_ready <= 1'b0;
            recv_data  <= '0;
            recv_ready <= 1'b0;
            byte_done  <= 1'b0;
            seen_rise  <= 1'b0;
        end else begin
            send_ready <= 1'b0;
            recv_ready <= 1'b0;
            byte_done  <= 1'b0;
            if (byte_done) begin
                recv_data  <= rx_shift;
                recv_ready <= 1'b1;
            end
            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (frame_start) begin
                        state      <= ACTIVE;
                        tx_shift   <= send_data[6:0];
                        miso       <= send_data[7];
                        send_ready <= 1'b1;
                        seen_rise  <= 1'b0;
                    end
                end
                default: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        miso      <= 1'b0;
                        seen_rise <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift  <= {rx_shift[6:0], mosi_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                        seen_rise <= 1'b1;
                        if (bit_cnt == 3'd7)
                            byte_done <= 1'b1;
                    end else if (sclk_fall) begin
                        if (bit_cnt != 3'd0) begin
                            miso     <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end else if (seen_rise) begin
                            tx_shift   <= send_data[6:0];
                            miso       <= send_data[7];
                            send_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_bytes <= '0;
            frame_end   <= 1'b0;
        end else begin
            frame_end <= (state == ACTIVE) && ss_rise;
            if (frame_start)
                frame_bytes <= '0;
            else if (byte_done && frame_bytes != 8'hFF)
                frame_bytes <= frame_bytes + 8'd1;
        end
    end
`endif

endmodule

// File: doc/spi_byte_slave.md
Name: spi_byte_slave

Overview:
- Byte-level SPI slave front end sitting directly upstream of the debug command decoder in the SPI SoC top.
- Oversamples the external SPI pins in the system clock domain, deserialises MOSI bytes, and serialises the decoder's reply byte onto MISO.
- Presents a one-cycle `recv_ready` strobe per received byte and a one-cycle `send_ready` strobe when the reply byte has been captured.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, SS active-low.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser (sclk, mosi, ss); legal range 2..4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- sclk  input  1  raw SPI clock from master, asynchronous to clk.
- mosi  input  1  raw SPI data from master.
- miso  output  1  SPI data to master.
- ss  input  1  raw slave select, active-low.
- send_data  input  8  reply byte for the next byte slot.
- send_ready  output  1  one-cycle pulse: send_data was captured into the TX shifter.
- recv_data  output  8  last complete received byte; held until the next byte completes.
- recv_ready  output  1  one-cycle pulse: recv_data is updated this cycle.
- frame_bytes  output  8  present only with SPI_SLAVE_FRAME_COUNT_EN.
- frame_end  output  1  present only with SPI_SLAVE_FRAME_COUNT_EN.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk. Reset is synchronous and active-high on `rst`.
  - Reset values: miso=0, send_ready=0, recv_data=0x00, recv_ready=0, bit counter=0, RX/TX shifters=0.
  - Synchroniser flops reset to idle levels: sclk=0, ss=1, mosi=0.
- Synchronisers and edge detection:
  - sclk, mosi and ss each pass through SYNC_STAGES flops. Edges are detected from the last synchronised stage and its delayed copy.
  - sclk_rise, sclk_fall, ss_fall and ss_rise are one-cycle pulses.
- Frame states (two-state FSM):
  - IDLE: synchronised ss=1. miso=0. Bit counter held at 0. sclk edges ignored.
  - ACTIVE: entered on ss_fall. On entry, load the TX shifter from send_data, drive its bit 7 on miso, and pulse send_ready in the same cycle.
- RX path: on sclk_rise in ACTIVE:
  - RX shifter becomes {rx[6:0], mosi_sync}; bit counter increments modulo 8.
  - When the counter wraps 7->0, the next cycle has recv_data = completed byte and recv_ready=1.
  - Latency: recv_ready asserts SYNC_STAGES+2 clk cycles after the first clk edge sampling the 8th raw sclk high.
- TX path: on sclk_fall in ACTIVE:
  - Counter != 0: shift TX left and drive the new bit 7 on miso.
  - Counter == 0 (byte boundary): reload the TX shifter from send_data, drive its bit 7, pulse send_ready.
  - The first sclk_fall of a frame, before any rise, is ignored.
- Timing contract:
  - f_clk >= 8 x f_sclk.
  - The consumer updates send_data within 2 clk cycles after recv_ready. It is guaranteed to be captured at the following boundary sclk_fall.
- Boundary conditions:
  - ss_rise mid-byte: return to IDLE. Partial RX bits are discarded, no recv_ready, counter cleared, miso=0.
  - Simultaneous ss_fall and sclk edge: ss_fall wins; the edge is ignored.
  - sclk_rise and sclk_fall in the same cycle are impossible given the synchroniser.
  - recv_data is never cleared except by rst; it holds across frames.
  - rst mid-frame: all state returns to reset values immediately on the next clk edge. The FSM re-enters ACTIVE only on a fresh ss_fall after reset deassertion, even if ss is still low.
- Metastability: none propagates past the synchronisers. Only the last stage feeds logic.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_COUNT_EN.
- With the macro defined:
  - frame_bytes counts completed bytes in the current SS frame. It is cleared to 0 on ss_fall, increments in the same cycle recv_ready asserts, and saturates at 255.
  - frame_end pulses for one cycle on ss_rise while in ACTIVE. frame_bytes holds its value until the next ss_fall.
  - Both outputs reset to 0.
- Without the macro: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then idle with ss=1 and sclk toggling -> miso=0, recv_ready never asserts, recv_data=0x00.
- ss low; master sends 0xA5 with send_data=0x3C held -> exactly one recv_ready pulse with recv_data=0xA5; master samples 0x3C on MISO; send_ready pulsed once at ss_fall.
- Two-byte frame 0x01, 0x5A; the consumer sets send_data=0x01 on the first recv_ready -> two recv_ready pulses (0x01 then 0x5A); second byte on MISO reads 0x01; second send_ready pulse at the boundary fall.
- ss deasserted after 5 bits of 0xFF, then a full frame 0x42 -> no recv_ready for the partial byte; the next frame yields recv_data=0x42.
- rst asserted for 1 cycle mid-byte (bit 3) with ss held low -> outputs at reset values; no recv_ready until ss toggles high then low and 8 new bits complete.
- With SPI_SLAVE_FRAME_COUNT_EN, a frame of 3 bytes then ss high -> frame_bytes=3, one frame_end pulse; next ss_fall -> frame_bytes=0.
